// File: rtl/video_timing_decoder.sv
// Recovers line/frame geometry from a ce_pix-qualified HS/VS/DE stream,
// locks onto a stable format and re-emits active pixels with x/y.
module video_timing_decoder #(
    parameter int HW          = 10,
    parameter int VW          = 10,
    parameter int LOCK_FRAMES = 2,
    parameter int PAL_LINES   = 288
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce_pix,
    input  logic          hs,
    input  logic          vs,
    input  logic          de,
    input  logic [7:0]    r,
    input  logic [7:0]    g,
    input  logic [7:0]    b,
    output logic          pix_valid,
    output logic [8:0]    pix_x,
    output logic [8:0]    pix_y,
    output logic [14:0]   pix_rgb,
    output logic          frame_start,
    output logic [HW-1:0] h_total,
    output logic [VW-1:0] v_total,
    output logic [HW-1:0] active_w,
    output logic [VW-1:0] active_h,
    output logic          pal_detected,
    output logic          locked,
    output logic          sync_err
);

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } state_t;

    localparam logic [HW-1:0] H_MAX    = '1;
    localparam logic [HW-1:0] H_NEAR   = H_MAX - 1'b1;
    localparam logic [VW-1:0] V_MAX    = '1;
    localparam logic [VW-1:0] V_NEAR   = V_MAX - 1'b1;
    localparam logic [VW-1:0] PAL_V    = VW'(PAL_LINES);
    localparam logic [7:0]    LOCK_TGT = 8'(LOCK_FRAMES - 1);

    state_t        state;
    logic [7:0]    match_cnt;
    logic          hs_q;
    logic          vs_q;
    logic          de_q;
    logic [HW-1:0] hc;
    logic [HW-1:0] h_sh;
    logic [HW-1:0] de_cnt;
    logic [HW-1:0] dew_sh;
    logic          line_de;
    logic [VW-1:0] vc;
    logic [VW-1:0] al;
    logic [8:0]    x_cnt;
    logic [8:0]    y_cnt;
    logic          vs_seen;

    logic          hs_rise;
    logic          vs_rise;
    logic          de_rise;
    logic          line_de_now;
    logic [HW-1:0] de_cnt_now;
    logic [HW-1:0] h_sh_nx;
    logic [HW-1:0] dew_nx;
    logic [VW-1:0] vc_nx;
    logic [VW-1:0] al_nx;
    logic          timeout;
    logic          frame_match;
    logic [7:0]    cnt_inc;
    logic [8:0]    x_now;
    logic [8:0]    y_now;
    logic          unused_lsb;

    assign unused_lsb = ^{r[2:0], g[2:0], b[2:0]};

    assign hs_rise = ce_pix & hs & ~hs_q;
    assign vs_rise = ce_pix & vs & ~vs_q;
    assign de_rise = ce_pix & de & ~de_q;

    // Line-close values; a frame commit on the same ce sees these, so a
    // coincident hs/vs rise closes the line before the frame.
    always_comb begin
        line_de_now = line_de | de;
        de_cnt_now  = de_cnt;
        if (de_rise)
            de_cnt_now = HW'(1);
        else if (de && de_cnt != H_MAX)
            de_cnt_now = de_cnt + 1'b1;
        h_sh_nx = h_sh;
        dew_nx  = dew_sh;
        vc_nx   = vc;
        al_nx   = al;
        if (hs_rise) begin
            h_sh_nx = (hc == H_MAX) ? H_MAX : hc + 1'b1;
            if (vc != V_MAX)
                vc_nx = vc + 1'b1;
            if (line_de_now) begin
                dew_nx = de_cnt_now;
                if (al != V_MAX)
                    al_nx = al + 1'b1;
            end
        end
    end

    always_comb begin
        timeout = (ce_pix & ~hs_rise & (hc == H_NEAR))
                | (hs_rise & (vc == V_NEAR));
        frame_match = (h_sh_nx == h_total) && (dew_nx == active_w)
                   && (vc_nx == v_total) && (al_nx == active_h);
        cnt_inc = match_cnt + 8'd1;
        x_now   = de_rise ? 9'd0 : x_cnt;
        y_now   = y_cnt;
        if (de_rise)
            y_now = vs_seen ? 9'd0 : y_cnt + 9'd1;
    end

    assign locked = (state == LOCKED);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= SEARCH;
            match_cnt    <= '0;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            de_q         <= 1'b0;
            hc           <= '0;
            h_sh         <= '0;
            de_cnt       <= '0;
            dew_sh       <= '0;
            line_de      <= 1'b0;
            vc           <= '0;
            al           <= '0;
            x_cnt        <= '0;
            y_cnt        <= '0;
            vs_seen      <= 1'b0;
            pix_valid    <= 1'b0;
            pix_x        <= '0;
            pix_y        <= '0;
            pix_rgb      <= '0;
            frame_start  <= 1'b0;
            h_total      <= '0;
            v_total      <= '0;
            active_w     <= '0;
            active_h     <= '0;
            pal_detected <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
            if (ce_pix) begin
                hs_q   <= hs;
                vs_q   <= vs;
                de_q   <= de;
                de_cnt <= de_cnt_now;

                if (hs_rise)
                    hc <= '0;
                else if (hc != H_MAX)
                    hc <= hc + 1'b1;

                if (hs_rise) begin
                    h_sh    <= h_sh_nx;
                    dew_sh  <= dew_nx;
                    vc      <= vc_nx;
                    al      <= al_nx;
                    line_de <= 1'b0;
                end else begin
                    line_de <= line_de_now;
                end

                if (vs_rise) begin
                    vc <= '0;
                    al <= '0;
                end

                if (de_rise) begin
                    x_cnt   <= 9'd1;
                    y_cnt   <= y_now;
                    vs_seen <= 1'b0;
                end else if (de) begin
                    x_cnt <= x_cnt + 9'd1;
                end
                if (vs_rise)
                    vs_seen <= 1'b1;

                if (state == LOCKED && de) begin
                    pix_valid   <= 1'b1;
                    pix_x       <= x_now;
                    pix_y       <= y_now;
                    pix_rgb     <= {b[7:3], g[7:3], r[7:3]};
                    frame_start <= (x_now == 9'd0) && (y_now == 9'd0);
                end

                if (timeout) begin
                    state     <= SEARCH;
                    match_cnt <= '0;
                    sync_err  <= (state == LOCKED);
                end else if (vs_rise) begin
                    unique case (state)
                        SEARCH: begin
                            state     <= MEASURE;
                            match_cnt <= '0;
                        end
                        MEASURE: begin
                            if (frame_match) begin
                                match_cnt <= cnt_inc;
                                if (cnt_inc >= LOCK_TGT)
                                    state <= LOCKED;
                            end else begin
                                match_cnt <= '0;
                            end
                        end
                        LOCKED: begin
                            if (!frame_match) begin
                                sync_err  <= 1'b1;
                                match_cnt <= '0;
                                state     <= MEASURE;
                            end
                        end
                        default: state <= SEARCH;
                    endcase
                    // The first frame seen from SEARCH is partial.
                    if (state != SEARCH) begin
                        h_total      <= h_sh_nx;
                        active_w     <= dew_nx;
                        v_total      <= vc_nx;
                        active_h     <= al_nx;
                        pal_detected <= (vc_nx >= PAL_V);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_video_timing_decoder.sv
// Bench for video_timing_decoder: scaled NTSC/PAL streams with random
// colour and ce gaps, checked against a frame-level reference model.
module tb_video_timing_decoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        ce_pix = 1'b0;
    logic        hs = 1'b0;
    logic        vs = 1'b0;
    logic        de = 1'b0;
    logic [7:0]  r = '0;
    logic [7:0]  g = '0;
    logic [7:0]  b = '0;
    logic        pix_valid;
    logic [8:0]  pix_x;
    logic [8:0]  pix_y;
    logic [14:0] pix_rgb;
    logic        frame_start;
    logic [9:0]  h_total;
    logic [9:0]  v_total;
    logic [9:0]  active_w;
    logic [9:0]  active_h;
    logic        pal_detected;
    logic        locked;
    logic        sync_err;

    always #5 clk = ~clk;

    video_timing_decoder dut (
        .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix),
        .hs(hs), .vs(vs), .de(de), .r(r), .g(g), .b(b),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_rgb(pix_rgb), .frame_start(frame_start),
        .h_total(h_total), .v_total(v_total),
        .active_w(active_w), .active_h(active_h),
        .pal_detected(pal_detected), .locked(locked),
        .sync_err(sync_err)
    );

    typedef enum int { M_SEARCH, M_MEAS, M_LOCK } mstate_t;

    int checks = 0;
    int errors = 0;

    // reference model state (frame level)
    mstate_t ms;
    int mc;
    int c_h, c_w, c_v, c_a;
    bit ph, pv, pd;
    int since_hs, vlines, dlines;
    int mx, my;
    bit seen;

    // stream generator
    int g_htot, g_hact, g_hs0, g_vtot, g_vact, g_vs0;
    int line, px;
    bit stop_sync;
    int ce_div;
    int n_valid, n_fs, n_se;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ms = M_SEARCH; mc = 0;
        c_h = 0; c_w = 0; c_v = 0; c_a = 0;
        ph = 0; pv = 0; pd = 0;
        since_hs = 0; vlines = 0; dlines = 0;
        mx = 0; my = 0; seen = 0;
    endtask

    task automatic check_zero(input string t);
        chk({t, "_valid"}, pix_valid, 0);
        chk({t, "_x"}, pix_x, 0);
        chk({t, "_y"}, pix_y, 0);
        chk({t, "_rgb"}, pix_rgb, 0);
        chk({t, "_fs"}, frame_start, 0);
        chk({t, "_htot"}, h_total, 0);
        chk({t, "_vtot"}, v_total, 0);
        chk({t, "_aw"}, active_w, 0);
        chk({t, "_ah"}, active_h, 0);
        chk({t, "_pal"}, pal_detected, 0);
        chk({t, "_lock"}, locked, 0);
        chk({t, "_serr"}, sync_err, 0);
    endtask

    task automatic sample(input bit h, input bit v, input bit d);
        logic [7:0] rr, gg, bb;
        bit hr, vr, dr, ev, ese, to, fm;
        int idle;
        idle = (ce_div > 0) ? ce_div - 1
             : (($urandom_range(0, 7) == 0) ? 1 : 0);
        repeat (idle) begin
            @(posedge clk); #1;
            chk("idle_valid", pix_valid, 0);
            chk("idle_serr", sync_err, 0);
        end
        rr = 8'($urandom); gg = 8'($urandom); bb = 8'($urandom);
        ce_pix = 1; hs = h; vs = v; de = d; r = rr; g = gg; b = bb;
        @(posedge clk); #1;
        ce_pix = 0;
        hr = h & !ph; vr = v & !pv; dr = d & !pd;
        ph = h; pv = v; pd = d;
        ev = (ms == M_LOCK) && d;
        if (dr) begin
            mx = 0;
            my = seen ? 0 : (my + 1) % 512;
            seen = 0;
        end else if (d) begin
            mx = (mx + 1) % 512;
        end
        if (vr) seen = 1;
        chk("pix_valid", pix_valid, ev);
        if (ev) begin
            chk("pix_x", pix_x, mx);
            chk("pix_y", pix_y, my);
            chk("pix_rgb", pix_rgb, {bb[7:3], gg[7:3], rr[7:3]});
            n_valid++;
        end
        chk("frame_start", frame_start, ev && mx == 0 && my == 0);
        if (frame_start) n_fs++;
        ese = 0; to = 0;
        if (hr) begin
            since_hs = 0;
            vlines++;
            if (line < g_vact) dlines++;
        end else if (since_hs < 1023) begin
            since_hs++;
            if (since_hs == 1023) begin
                to = 1;
                ese = (ms == M_LOCK);
                ms = M_SEARCH; mc = 0;
            end
        end
        if (vr && !to) begin
            fm = (g_htot == c_h) && (g_hact == c_w)
              && (vlines == c_v) && (dlines == c_a);
            if (ms == M_SEARCH) begin
                ms = M_MEAS; mc = 0;
            end else begin
                if (ms == M_MEAS) begin
                    if (fm) begin
                        mc++;
                        if (mc >= 1) ms = M_LOCK;
                    end else mc = 0;
                end else if (!fm) begin
                    ese = 1; mc = 0; ms = M_MEAS;
                end
                c_h = g_htot; c_w = g_hact; c_v = vlines; c_a = dlines;
            end
            vlines = 0; dlines = 0;
            chk("h_total", h_total, c_h);
            chk("active_w", active_w, c_w);
            chk("v_total", v_total, c_v);
            chk("active_h", active_h, c_a);
            chk("pal", pal_detected, c_v >= 288);
        end
        chk("sync_err", sync_err, ese);
        if (sync_err) n_se++;
        chk("locked", locked, ms == M_LOCK);
    endtask

    task automatic step();
        bit h, v, d;
        h = !stop_sync && px >= g_hs0 && px < g_hs0 + 2;
        v = !stop_sync && line >= g_vs0 && line < g_vs0 + 3;
        d = line < g_vact && px < g_hact;
        sample(h, v, d);
        px++;
        if (px == g_htot) begin
            px = 0; line++;
            if (line >= g_vtot) line = 0;
        end
    endtask

    task automatic run_frames(input int n);
        repeat (n) begin
            do step(); while (!(line == 0 && px == 0));
        end
    endtask

    task automatic run_to(input int l, input int p);
        int guard;
        guard = 0;
        while (!(line == l && px == p)) begin
            step();
            guard++;
            if (guard > 20000) begin
                chk("run_to_bound", guard, 0);
                break;
            end
        end
    endtask

    task automatic set_ntsc();
        g_htot = 10; g_hact = 6; g_hs0 = 7;
        g_vtot = 262; g_vact = 240; g_vs0 = 244;
    endtask

    int se0, v0, fs0;

    initial begin
        model_reset();
        set_ntsc();
        line = 0; px = 0; stop_sync = 0; ce_div = 0;
        n_valid = 0; n_fs = 0; n_se = 0;
        #2 reset_n = 0;
        #1 check_zero("por");
        repeat (2) @(posedge clk);
        #1 reset_n = 1;

        // NTSC lock after third vs rise
        run_frames(1);
        run_to(245, 0);
        chk("ntsc_2vs_lock", locked, 0);
        run_frames(1);
        run_to(245, 0);
        chk("ntsc_lock", locked, 1);
        chk("ntsc_htot", h_total, 10);
        chk("ntsc_vtot", v_total, 262);
        chk("ntsc_aw", active_w, 6);
        chk("ntsc_ah", active_h, 240);
        chk("ntsc_pal", pal_detected, 0);
        run_frames(1);

        // one full frame with ce_pix every 4th clock
        ce_div = 4; v0 = n_valid; fs0 = n_fs;
        run_frames(1);
        ce_div = 0;
        chk("ce4_valid_cnt", n_valid - v0, 240 * 6);
        chk("ce4_fs_cnt", n_fs - fs0, 1);
        chk("ce4_lock", locked, 1);

        // one 261-line frame, then relock
        se0 = n_se;
        g_vtot = 261;
        run_frames(1);
        g_vtot = 262;
        run_to(245, 0);
        chk("short_unlock", locked, 0);
        run_frames(1);
        run_to(245, 0);
        chk("short_meas", locked, 0);
        run_frames(1);
        run_to(245, 0);
        chk("relock", locked, 1);
        chk("short_serr_cnt", n_se - se0, 1);
        chk("short_vtot", v_total, 262);

        // asynchronous reset mid-line while locked
        run_to(250, 3);
        #2 reset_n = 0;
        #1 check_zero("rst");
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1;
        model_reset();
        run_frames(1);
        run_to(245, 0);
        chk("rst_1vs", locked, 0);
        run_frames(1);
        run_to(245, 0);
        chk("rst_2vs", locked, 0);
        run_frames(1);
        run_to(243, 0);
        chk("rst_pre3", locked, 0);
        run_to(245, 0);
        chk("rst_3vs", locked, 1);
        run_frames(1);

        // PAL geometry
        g_htot = 8; g_hact = 4; g_hs0 = 5;
        g_vtot = 312; g_vs0 = 270;
        run_frames(2);
        run_to(271, 0);
        chk("pal_lock", locked, 1);
        chk("pal_vtot", v_total, 312);
        chk("pal_flag", pal_detected, 1);
        chk("pal_htot", h_total, 8);
        chk("pal_aw", active_w, 4);

        // syncs stop while locked
        run_to(280, 0);
        se0 = n_se;
        stop_sync = 1;
        repeat (1100) step();
        chk("to_serr_cnt", n_se - se0, 1);
        chk("to_lock", locked, 0);
        v0 = n_valid;
        repeat (40) step();
        chk("to_no_valid", n_valid - v0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
